// File: rtl/compare_pkg.sv
// compare_pkg: shared width default, compare result encoding and magnitude helper.
package compare_pkg;
    localparam int CMP_WIDTH_DEFAULT = 8;
    typedef enum logic [1:0] {EQ = 2'd0, GT = 2'd1, LT = 2'd2} cmp_res_t;
    // Operands arrive already zero- or sign-extended to 64 bits by the caller.
    function automatic cmp_res_t cmp_eval(input logic [63:0] a, input logic [63:0] b, input logic is_signed);
        if (a == b) return EQ;
        if (is_signed) return ($signed(a) > $signed(b)) ? GT : LT;
        return (a > b) ? GT : LT;
    endfunction
endpackage

// File: rtl/compare_8bit_if.sv
// compare_8bit_if: operand/result bundle; gt and lt exist only with COMPARE_MAG_EN.
interface compare_8bit_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             equal;
`ifdef COMPARE_MAG_EN
    logic             gt;
    logic             lt;
`endif
    modport master (
        output in_valid, a, b,
        input  out_valid, equal
`ifdef COMPARE_MAG_EN
        , input gt, lt
`endif
    );
    modport slave (
        input  in_valid, a, b,
        output out_valid, equal
`ifdef COMPARE_MAG_EN
        , output gt, lt
`endif
    );
endinterface

// File: rtl/compare_core.sv
// compare_core: combinational equality and (with COMPARE_MAG_EN) magnitude compare.
module compare_core
    import compare_pkg::*;
#(
    parameter int WIDTH      = CMP_WIDTH_DEFAULT,
    parameter int SIGNED_CMP = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             eq_o
`ifdef COMPARE_MAG_EN
    ,
    output logic             gt_o,
    output logic             lt_o
`endif
);
    if (WIDTH < 1 || WIDTH > 63 || (SIGNED_CMP != 0 && SIGNED_CMP != 1)) begin : g_bad_cfg
        $error("compare_core: unsupported WIDTH/SIGNED_CMP");
    end
    assign eq_o = ~|(a_i ^ b_i);
`ifdef COMPARE_MAG_EN
    localparam int PAD = 64 - WIDTH;
    logic [63:0] a_x;
    logic [63:0] b_x;
    cmp_res_t    res;
    assign a_x  = {{PAD{SIGNED_CMP != 0 && a_i[WIDTH-1]}}, a_i};
    assign b_x  = {{PAD{SIGNED_CMP != 0 && b_i[WIDTH-1]}}, b_i};
    assign res  = cmp_eval(a_x, b_x, SIGNED_CMP != 0);
    assign gt_o = (res == GT);
    assign lt_o = (res == LT);
`endif
endmodule

// File: rtl/compare_8bit.sv
// compare_8bit: registered comparator, one-cycle latency, results hold while idle.
// Optional gt/lt outputs built when COMPARE_MAG_EN is defined.
module compare_8bit
    import compare_pkg::*;
#(
    parameter int WIDTH      = CMP_WIDTH_DEFAULT,
    parameter int SIGNED_CMP = 0
) (
    input logic          clk,
    input logic          rst,
    compare_8bit_if.slave bus
);
    logic eq_c;
    logic valid_q, valid_d;
    logic eq_q, eq_d;
`ifdef COMPARE_MAG_EN
    logic gt_c, lt_c;
    logic gt_q, gt_d;
    logic lt_q, lt_d;
`endif
    compare_core #(.WIDTH(WIDTH), .SIGNED_CMP(SIGNED_CMP)) u_core (
        .a_i  (bus.a),
        .b_i  (bus.b),
        .eq_o (eq_c)
`ifdef COMPARE_MAG_EN
        ,
        .gt_o (gt_c),
        .lt_o (lt_c)
`endif
    );
    always_comb begin
        valid_d = bus.in_valid;
        eq_d    = bus.in_valid ? eq_c : eq_q;
`ifdef COMPARE_MAG_EN
        gt_d    = bus.in_valid ? gt_c : gt_q;
        lt_d    = bus.in_valid ? lt_c : lt_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            eq_q    <= 1'b0;
`ifdef COMPARE_MAG_EN
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            eq_q    <= eq_d;
`ifdef COMPARE_MAG_EN
            gt_q    <= gt_d;
            lt_q    <= lt_d;
`endif
        end
    end
    assign bus.out_valid = valid_q;
    assign bus.equal     = eq_q;
`ifdef COMPARE_MAG_EN
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
`endif
endmodule

// File: tb/tb_compare_8bit.sv
// tb_compare_8bit: scoreboard bench driving an unsigned and a signed instance in lockstep.
module tb_compare_8bit;
    typedef struct {
        logic eq;
        logic gu;
        logic lu;
        logic gs;
        logic ls;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    compare_8bit_if #(.WIDTH(8)) bus_u ();
    compare_8bit_if #(.WIDTH(8)) bus_s ();

    compare_8bit #(.WIDTH(8), .SIGNED_CMP(0)) u_dut (.clk(clk), .rst(rst), .bus(bus_u));
    compare_8bit #(.WIDTH(8), .SIGNED_CMP(1)) s_dut (.clk(clk), .rst(rst), .bus(bus_s));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        bus_u.in_valid = v;
        bus_u.a        = a;
        bus_u.b        = b;
        bus_s.in_valid = v;
        bus_s.a        = a;
        bus_s.b        = b;
    endtask

    // Issue one accepted pair with its hand-computed results; returns 1 time unit after the edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic eq,
                        input logic gu, input logic lu, input logic gs, input logic ls);
        exp_t e;
        e.eq = eq; e.gu = gu; e.lu = lu; e.gs = gs; e.ls = ls;
        drive(1'b1, a, b);
        q.push_back(e);
        @(posedge clk);
        #1;
        chk("out_valid_high", {31'd0, bus_u.out_valid}, 32'd1);
    endtask

    task automatic idle(input logic [7:0] a, input logic [7:0] b, input logic eq_hold);
        drive(1'b0, a, b);
        @(posedge clk);
        #1;
        chk("idle_out_valid", {31'd0, bus_u.out_valid}, 32'd0);
        chk("idle_equal_hold", {31'd0, bus_u.equal}, {31'd0, eq_hold});
`ifdef COMPARE_MAG_EN
        chk("idle_gt_hold", {31'd0, bus_u.gt}, 32'd0);
        chk("idle_lt_hold", {31'd0, bus_u.lt}, 32'd0);
`endif
    endtask

    always @(negedge clk) begin
        if (bus_u.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", {31'd0, bus_u.out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("equal_u", {31'd0, bus_u.equal}, {31'd0, e.eq});
                chk("equal_s", {31'd0, bus_s.equal}, {31'd0, e.eq});
                chk("out_valid_s", {31'd0, bus_s.out_valid}, 32'd1);
`ifdef COMPARE_MAG_EN
                chk("gt_u", {31'd0, bus_u.gt}, {31'd0, e.gu});
                chk("lt_u", {31'd0, bus_u.lt}, {31'd0, e.lu});
                chk("gt_s", {31'd0, bus_s.gt}, {31'd0, e.gs});
                chk("lt_s", {31'd0, bus_s.lt}, {31'd0, e.ls});
                chk("onehot_u", {31'd0, $onehot({bus_u.equal, bus_u.gt, bus_u.lt})}, 32'd1);
                chk("onehot_s", {31'd0, $onehot({bus_s.equal, bus_s.gt, bus_s.lt})}, 32'd1);
`endif
            end
        end
    end

    initial begin
        logic [7:0] ra, rb;
        drive(1'b1, 8'h00, 8'h00);
        // Reset wins over a valid input; nothing is queued for these cycles.
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_out_valid", {31'd0, bus_u.out_valid}, 32'd0);
            chk("rst_equal", {31'd0, bus_u.equal}, 32'd0);
            chk("rst_out_valid_s", {31'd0, bus_s.out_valid}, 32'd0);
        end
        rst = 1'b0;
        //   a      b      eq    gu    lu    gs    ls
        send(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(8'hBC, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8'h12, 8'h34, 1'b1);
        idle(8'hFF, 8'h00, 1'b1);
        idle(8'h01, 8'h81, 1'b1);
        send(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10000; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            send(ra, rb, ra == rb, ra > rb, ra < rb, $signed(ra) > $signed(rb), $signed(ra) < $signed(rb));
        end
        drive(1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
